mem_access_ctrl: RTL and testbench
==================================

// Module: mem_access_ctrl
// PURPOSE
//  Load/store controller between the pipeline MEM stage and the data memory; sole driver of its port.
//  Takes one load/store request (RV32 funct3 + byte address + store data) over a valid/ready handshake.
//  Drives the memory's read_write/access_size/address/data_in and consumes its combinational data_out.
//  Sign/zero-extends loads and splits misaligned accesses into byte accesses; returns data on a response handshake.
// PARAMETERS
//  DMEM_BASE   32'h01000000  byte address of data memory byte 0
//  DMEM_BYTES  32'h00100000  data memory size in bytes; accesses outside [BASE, BASE+BYTES) are errors
// PORTS
//  clock       in   1   single clock, all state on posedge
//  reset_n     in   1   asynchronous, active-low reset
//  req_valid   in   1   request present
//  req_ready   out  1   controller can accept; high only in IDLE
//  req_write   in   1   1 = store, 0 = load
//  req_funct3  in   3   RV32 funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU (BU/HU loads only)
//  req_addr    in   32  byte address
//  req_wdata   in   32  store data, LSBs used
//  rsp_valid   out  1   response present; held until rsp_ready
//  rsp_ready   in   1   consumer takes response
//  rsp_rdata   out  32  extended load data; 0 for stores and errors
//  rsp_error   out  1   illegal funct3, out-of-range, or (with MISALIGNED_TRAP_EN) misaligned
//  mem_read_write   out 1   1 = write this cycle (memory commits at posedge)
//  mem_access_size  out 2   00 byte, 01 half, 10 word
//  mem_address      out 32  byte address
//  mem_data_in      out 32  write data
//  mem_data_out     in  32  combinational, zero-extended read data
// BEHAVIOUR
//  Reset (async, reset_n=0)
//   - State IDLE; req_ready=0 while reset_n=0; rsp_valid=0, rsp_rdata=0, rsp_error=0.
//   - Memory port idle: read_write=0, size=10, address=DMEM_BASE, data_in=0.
//   - Reset mid-split: already-committed store bytes stay written; no response is produced.
//  States IDLE -> ACCESS | SPLIT | RESP -> IDLE
//   - IDLE: req_ready=1. On req_valid: register the request, then
//       illegal funct3 (011/110/111; stores with funct3[2]=1) -> RESP, error, no memory access
//       range fail (addr<BASE or addr-BASE+nbytes>BYTES) -> RESP, error, no memory access
//       aligned -> ACCESS; misaligned -> SPLIT
//   - ACCESS (1 cycle): drive size per width, address=req_addr, data_in=wdata, read_write=req_write.
//       Load data captured at the closing posedge -> RESP.
//   - SPLIT: nbytes = 2 (H) or 4 (W); 2-bit counter k = 0..nbytes-1.
//       Per cycle: byte access at addr+k, data_in = wdata byte k in [7:0].
//       Loads put mem_data_out[7:0] into byte lane k. Leave for RESP after k = nbytes-1.
//   - RESP: rsp_valid=1, outputs stable until rsp_ready; then -> IDLE.
//       No accept in the RESP->IDLE cycle (req_ready is 0 in RESP).
//  Latency and width rules
//   - Accept at cycle 0; aligned rsp_valid at cycle 2; misaligned at cycle 1+nbytes; error at cycle 1.
//   - Misaligned: H with addr[0]=1; W with addr[1:0]!=0. Bytes always aligned.
//   - Load extension: B/H sign-extend bit 7/15; BU/HU zero-extend; W as-is.
//   - Memory port is idle in every state except ACCESS/SPLIT; never writes outside them.
// CONFIGURATION
//  MISALIGNED_TRAP_EN
//   - Defined: misaligned requests skip memory, go IDLE->RESP with rsp_error=1, rdata=0; SPLIT unused.
//   - Undefined: misaligned requests split as above and complete with rsp_error=0.
// TESTING
//  - Store W 0xDEADBEEF @0x01000010, then LW @0x01000010 -> rsp_rdata=0xDEADBEEF, error=0, rsp_valid 2 cyc after accept.
//  - Memory byte @0x01000011 = 0x80: LB -> 0xFFFFFF80, LBU -> 0x00000080; LH @0x01000010 on 0x80EF -> 0xFFFF80EF.
//  - SW 0x11223344 @0x01000021 (trap off) -> 4 byte writes 0x44,0x33,0x22,0x11 @0x21..0x24; LW back = 0x11223344, rsp after 5 cyc.
//      With MISALIGNED_TRAP_EN: rsp_error=1 at cycle 1, memory unchanged.
//  - funct3=011 load, and LW @0x00FFFFFC -> rsp_error=1, rdata=0, mem_read_write never 1.
//  - Hold rsp_ready=0 for 5 cycles -> rsp_valid/rdata stable, req_ready=0; release -> IDLE the next cycle.
//  - Assert reset_n=0 at k=1 of a misaligned SW -> only byte 0 written, rsp_valid=0, port idle, IDLE after release.

Source files
------------

// File: rtl/mem_access_ctrl.sv
// Load/store controller between the MEM stage and the data memory port.
// Build option: define MISALIGNED_TRAP_EN to trap misaligned accesses instead of splitting them.
module mem_access_ctrl #(
  parameter logic [31:0] DMEM_BASE  = 32'h0100_0000,
  parameter logic [31:0] DMEM_BYTES = 32'h0010_0000
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_error,
  output logic        mem_read_write,
  output logic [1:0]  mem_access_size,
  output logic [31:0] mem_address,
  output logic [31:0] mem_data_in,
  input  logic [31:0] mem_data_out
);

  localparam int unsigned XLEN  = 32;
  localparam int unsigned OFF_W = XLEN + 1;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_SPLIT,
    S_RESP
  } state_t;

  // RV32 load extension: B/H sign-extend, BU/HU zero-extend, W unchanged.
  function automatic logic [XLEN-1:0] extend_load(input logic [2:0] funct3,
                                                  input logic [XLEN-1:0] data);
    case (funct3)
      3'b000:  return {{24{data[7]}}, data[7:0]};
      3'b001:  return {{16{data[15]}}, data[15:0]};
      3'b100:  return {24'h0, data[7:0]};
      3'b101:  return {16'h0, data[15:0]};
      default: return data;
    endcase
  endfunction

  state_t          state_q, state_d;
  logic [1:0]      k_q, k_d;
  logic            write_q, write_d;
  logic [2:0]      funct3_q, funct3_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  logic [XLEN-1:0] acc_q, acc_d;

  logic            req_ready_d;
  logic            rsp_valid_d;
  logic            rsp_error_d;
  logic [XLEN-1:0] rsp_rdata_d;
  logic            mem_rw_d;
  logic [1:0]      mem_size_d;
  logic [XLEN-1:0] mem_addr_d;
  logic [XLEN-1:0] mem_wdata_d;

  logic             illegal;
  logic             out_of_range;
  logic             misaligned;
  logic [2:0]       nbytes;
  logic [OFF_W-1:0] end_offset;

  logic [XLEN-1:0] merged;
  logic [1:0]      last_k;
  logic [1:0]      k_next;

  // Classify the request on the input ports; only consulted while accepting in IDLE.
  always_comb begin
    case (req_funct3[1:0])
      2'b00:   nbytes = 3'd1;
      2'b01:   nbytes = 3'd2;
      default: nbytes = 3'd4;
    endcase
    illegal      = (req_funct3[1:0] == 2'b11) ||
                   (req_funct3[2] && (req_write || req_funct3[1]));
    end_offset   = OFF_W'(req_addr - DMEM_BASE) + OFF_W'(nbytes);
    out_of_range = (req_addr < DMEM_BASE) || (end_offset > OFF_W'(DMEM_BYTES));
    misaligned   = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                   ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
  end

  // Split datapath: byte k of the current access lands in lane k of the accumulator.
  always_comb begin
    last_k = (funct3_q[1:0] == 2'b01) ? 2'd1 : 2'd3;
    k_next = k_q + 2'd1;
    merged = acc_q;
    merged[{k_q, 3'b000} +: 8] = mem_data_out[7:0];
  end

  // Next state plus next value of every registered output.
  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    write_d     = write_q;
    funct3_d    = funct3_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    acc_d       = acc_q;
    rsp_valid_d = rsp_valid;
    rsp_error_d = rsp_error;
    rsp_rdata_d = rsp_rdata;
    mem_rw_d    = 1'b0;
    mem_size_d  = SIZE_WORD;
    mem_addr_d  = DMEM_BASE;
    mem_wdata_d = '0;

    case (state_q)
      S_IDLE: begin
        if (req_valid && req_ready) begin
          write_d     = req_write;
          funct3_d    = req_funct3;
          addr_d      = req_addr;
          wdata_d     = req_wdata;
          acc_d       = '0;
          k_d         = 2'd0;
          rsp_rdata_d = '0;
          rsp_error_d = 1'b0;
          if (illegal || out_of_range) begin
            state_d     = S_RESP;
            rsp_valid_d = 1'b1;
            rsp_error_d = 1'b1;
          end else if (misaligned) begin
`ifdef MISALIGNED_TRAP_EN
            state_d     = S_RESP;
            rsp_valid_d = 1'b1;
            rsp_error_d = 1'b1;
`else
            state_d     = S_SPLIT;
            mem_rw_d    = req_write;
            mem_size_d  = SIZE_BYTE;
            mem_addr_d  = req_addr;
            mem_wdata_d = {24'h0, req_wdata[7:0]};
`endif
          end else begin
            state_d     = S_ACCESS;
            mem_rw_d    = req_write;
            mem_size_d  = (nbytes == 3'd1) ? SIZE_BYTE :
                          (nbytes == 3'd2) ? SIZE_HALF : SIZE_WORD;
            mem_addr_d  = req_addr;
            mem_wdata_d = req_wdata;
          end
        end
      end

      S_ACCESS: begin
        state_d     = S_RESP;
        rsp_valid_d = 1'b1;
        rsp_rdata_d = write_q ? '0 : extend_load(funct3_q, mem_data_out);
      end

      S_SPLIT: begin
        acc_d = merged;
        if (k_q == last_k) begin
          state_d     = S_RESP;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = write_q ? '0 : extend_load(funct3_q, merged);
        end else begin
          k_d         = k_next;
          mem_rw_d    = write_q;
          mem_size_d  = SIZE_BYTE;
          mem_addr_d  = addr_q + XLEN'(k_next);
          mem_wdata_d = {24'h0, wdata_q[{k_next, 3'b000} +: 8]};
        end
      end

      S_RESP: begin
        if (rsp_ready) begin
          state_d     = S_IDLE;
          rsp_valid_d = 1'b0;
          rsp_error_d = 1'b0;
          rsp_rdata_d = '0;
        end
      end

      default: state_d = S_IDLE;
    endcase

    req_ready_d = (state_d == S_IDLE);
  end

  // State and output registers; reset parks the memory port idle.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q         <= S_IDLE;
      k_q             <= 2'd0;
      write_q         <= 1'b0;
      funct3_q        <= 3'b000;
      addr_q          <= '0;
      wdata_q         <= '0;
      acc_q           <= '0;
      req_ready       <= 1'b0;
      rsp_valid       <= 1'b0;
      rsp_error       <= 1'b0;
      rsp_rdata       <= '0;
      mem_read_write  <= 1'b0;
      mem_access_size <= SIZE_WORD;
      mem_address     <= DMEM_BASE;
      mem_data_in     <= '0;
    end else begin
      state_q         <= state_d;
      k_q             <= k_d;
      write_q         <= write_d;
      funct3_q        <= funct3_d;
      addr_q          <= addr_d;
      wdata_q         <= wdata_d;
      acc_q           <= acc_d;
      req_ready       <= req_ready_d;
      rsp_valid       <= rsp_valid_d;
      rsp_error       <= rsp_error_d;
      rsp_rdata       <= rsp_rdata_d;
      mem_read_write  <= mem_rw_d;
      mem_access_size <= mem_size_d;
      mem_address     <= mem_addr_d;
      mem_data_in     <= mem_wdata_d;
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl with a 256-byte behavioural data memory.
// Expectations follow MISALIGNED_TRAP_EN when the bench is built with it.
module tb_mem_access_ctrl;

  localparam logic [31:0] BASE = 32'h0100_0000;
`ifdef MISALIGNED_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic        clock;
  logic        reset_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_error;
  logic        mem_read_write;
  logic [1:0]  mem_access_size;
  logic [31:0] mem_address;
  logic [31:0] mem_data_in;
  logic [31:0] mem_data_out;

  int checks = 0;
  int fails  = 0;
  int wr_total = 0;
  int wr_base  = 0;

  mem_access_ctrl dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_write      (req_write),
    .req_funct3     (req_funct3),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .rsp_valid      (rsp_valid),
    .rsp_ready      (rsp_ready),
    .rsp_rdata      (rsp_rdata),
    .rsp_error      (rsp_error),
    .mem_read_write (mem_read_write),
    .mem_access_size(mem_access_size),
    .mem_address    (mem_address),
    .mem_data_in    (mem_data_in),
    .mem_data_out   (mem_data_out)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Behavioural memory: combinational zero-extended read, write committed at posedge.
  logic [7:0] mem [0:255] = '{default: 8'h00};
  logic [7:0] mix;
  always_comb begin
    mix = mem_address[7:0];
    case (mem_access_size)
      2'b00:   mem_data_out = {24'h0, mem[mix]};
      2'b01:   mem_data_out = {16'h0, mem[mix + 8'd1], mem[mix]};
      default: mem_data_out = {mem[mix + 8'd3], mem[mix + 8'd2], mem[mix + 8'd1], mem[mix]};
    endcase
  end

  always @(posedge clock) begin
    if (mem_read_write === 1'b1) begin
      wr_total <= wr_total + 1;
      mem[mem_address[7:0]] <= mem_data_in[7:0];
      if (mem_access_size != 2'b00) mem[mem_address[7:0] + 8'd1] <= mem_data_in[15:8];
      if (mem_access_size == 2'b10) begin
        mem[mem_address[7:0] + 8'd2] <= mem_data_in[23:16];
        mem[mem_address[7:0] + 8'd3] <= mem_data_in[31:24];
      end
    end
  end

  function automatic logic [31:0] word_at(input logic [7:0] a);
    return {mem[a + 8'd3], mem[a + 8'd2], mem[a + 8'd1], mem[a]};
  endfunction

  // Present one request and return at the falling edge of the cycle after acceptance.
  task automatic issue(input logic w, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] d);
    int n;
    n = 0;
    while (req_ready !== 1'b1 && n < 20) begin
      @(negedge clock);
      n++;
    end
    wr_base    = wr_total;
    req_valid  = 1'b1;
    req_write  = w;
    req_funct3 = f3;
    req_addr   = a;
    req_wdata  = d;
    @(posedge clock);
    @(negedge clock);
    req_valid = 1'b0;
  endtask

  // Full transaction: latency counts cycles from the accept edge to rsp_valid.
  task automatic do_txn(input logic w, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] d, output logic [31:0] rd, output logic er,
                        output int lat, output int nw);
    issue(w, f3, a, d);
    lat = 1;
    while (rsp_valid !== 1'b1 && lat < 20) begin
      @(negedge clock);
      lat++;
    end
    rd = rsp_rdata;
    er = rsp_error;
    rsp_ready = 1'b1;
    @(posedge clock);
    @(negedge clock);
    rsp_ready = 1'b0;
    nw = wr_total - wr_base;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) @(negedge clock);
    checks++;
    if (req_ready !== 1'b0 || rsp_valid !== 1'b0 || rsp_error !== 1'b0 || rsp_rdata !== 32'h0) begin
      fails++;
      $display("FAIL reset_rsp: ready=%b valid=%b err=%b rdata=%h, required 0 0 0 00000000",
               req_ready, rsp_valid, rsp_error, rsp_rdata);
    end
    checks++;
    if (mem_read_write !== 1'b0 || mem_access_size !== 2'b10 || mem_address !== BASE ||
        mem_data_in !== 32'h0) begin
      fails++;
      $display("FAIL reset_port: rw=%b size=%b addr=%h din=%h, required 0 10 %h 00000000",
               mem_read_write, mem_access_size, mem_address, mem_data_in, BASE);
    end
    reset_n = 1'b1;
    @(negedge clock);
    checks++;
    if (req_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_release_ready: got %b required 1", req_ready);
    end
  endtask

  task automatic test_aligned();
    logic [31:0] rd;
    logic er;
    int lat, nw;
    do_txn(1'b1, 3'b010, BASE + 32'h10, 32'hDEADBEEF, rd, er, lat, nw);
    checks++;
    if (er !== 1'b0 || lat != 2 || nw != 1 || word_at(8'h10) !== 32'hDEADBEEF) begin
      fails++;
      $display("FAIL sw_aligned: err=%b lat=%0d writes=%0d mem=%h, required 0 2 1 deadbeef",
               er, lat, nw, word_at(8'h10));
    end
    do_txn(1'b0, 3'b010, BASE + 32'h10, 32'h0, rd, er, lat, nw);
    checks++;
    if (rd !== 32'hDEADBEEF || er !== 1'b0 || lat != 2 || nw != 0) begin
      fails++;
      $display("FAIL lw_aligned: rdata=%h err=%b lat=%0d writes=%0d, required deadbeef 0 2 0",
               rd, er, lat, nw);
    end
    do_txn(1'b1, 3'b000, BASE + 32'h11, 32'hFFFF_FF80, rd, er, lat, nw);
    checks++;
    if (er !== 1'b0 || lat != 2 || nw != 1 || word_at(8'h10) !== 32'hDEAD80EF) begin
      fails++;
      $display("FAIL sb_aligned: err=%b lat=%0d writes=%0d mem=%h, required 0 2 1 dead80ef",
               er, lat, nw, word_at(8'h10));
    end
  endtask

  // Memory 0x10..0x13 holds EF 80 AD DE at this point.
  logic [2:0]  ld_f3  [6] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b000, 3'b001};
  logic [31:0] ld_off [6] = '{32'h11, 32'h11, 32'h10, 32'h10, 32'h10, 32'h12};
  logic [31:0] ld_exp [6] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_80EF,
                              32'h0000_80EF, 32'hFFFF_FFEF, 32'hFFFF_DEAD};

  task automatic test_load_extend();
    logic [31:0] rd;
    logic er;
    int lat, nw;
    for (int i = 0; i < 6; i++) begin
      do_txn(1'b0, ld_f3[i], BASE + ld_off[i], 32'h0, rd, er, lat, nw);
      checks++;
      if (rd !== ld_exp[i] || er !== 1'b0 || lat != 2) begin
        fails++;
        $display("FAIL load_extend[%0d]: rdata=%h err=%b lat=%0d, required %h 0 2",
                 i, rd, er, lat, ld_exp[i]);
      end
    end
  endtask

  task automatic test_misaligned();
    logic [31:0] rd;
    logic er;
    int lat, nw;
    do_txn(1'b1, 3'b010, BASE + 32'h21, 32'h11223344, rd, er, lat, nw);
    checks++;
    if (er !== TRAP || lat != (TRAP ? 1 : 5) || nw != (TRAP ? 0 : 4) || rd !== 32'h0) begin
      fails++;
      $display("FAIL sw_misaligned: err=%b lat=%0d writes=%0d rdata=%h, required %b %0d %0d 0",
               er, lat, nw, rd, TRAP, TRAP ? 1 : 5, TRAP ? 0 : 4);
    end
    checks++;
    if (word_at(8'h21) !== (TRAP ? 32'h0 : 32'h11223344)) begin
      fails++;
      $display("FAIL sw_misaligned_mem: got %h required %h",
               word_at(8'h21), TRAP ? 32'h0 : 32'h11223344);
    end
    do_txn(1'b0, 3'b010, BASE + 32'h21, 32'h0, rd, er, lat, nw);
    checks++;
    if (rd !== (TRAP ? 32'h0 : 32'h11223344) || er !== TRAP || lat != (TRAP ? 1 : 5)) begin
      fails++;
      $display("FAIL lw_misaligned: rdata=%h err=%b lat=%0d, required %h %b %0d",
               rd, er, lat, TRAP ? 32'h0 : 32'h11223344, TRAP, TRAP ? 1 : 5);
    end
    do_txn(1'b0, 3'b001, BASE + 32'h11, 32'h0, rd, er, lat, nw);
    checks++;
    if (rd !== (TRAP ? 32'h0 : 32'hFFFF_AD80) || er !== TRAP || lat != (TRAP ? 1 : 3)) begin
      fails++;
      $display("FAIL lh_misaligned: rdata=%h err=%b lat=%0d, required %h %b %0d",
               rd, er, lat, TRAP ? 32'h0 : 32'hFFFF_AD80, TRAP, TRAP ? 1 : 3);
    end
    do_txn(1'b0, 3'b101, BASE + 32'h11, 32'h0, rd, er, lat, nw);
    checks++;
    if (rd !== (TRAP ? 32'h0 : 32'h0000_AD80) || er !== TRAP) begin
      fails++;
      $display("FAIL lhu_misaligned: rdata=%h err=%b, required %h %b",
               rd, er, TRAP ? 32'h0 : 32'h0000_AD80, TRAP);
    end
    do_txn(1'b1, 3'b001, BASE + 32'h27, 32'h0000_5566, rd, er, lat, nw);
    checks++;
    if (er !== TRAP || nw != (TRAP ? 0 : 2) || lat != (TRAP ? 1 : 3) ||
        {mem[8'h28], mem[8'h27]} !== (TRAP ? 16'h0 : 16'h5566)) begin
      fails++;
      $display("FAIL sh_misaligned: err=%b writes=%0d lat=%0d mem=%h, required %b %0d %0d %h",
               er, nw, lat, {mem[8'h28], mem[8'h27]}, TRAP, TRAP ? 0 : 2, TRAP ? 1 : 3,
               TRAP ? 16'h0 : 16'h5566);
    end
  endtask

  // Error cases: illegal funct3 or out of range; none may touch memory.
  logic        er_w   [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
  logic [2:0]  er_f3  [6] = '{3'b011, 3'b110, 3'b100, 3'b010, 3'b010, 3'b001};
  logic [31:0] er_a   [6] = '{32'h0100_0010, 32'h0100_0010, 32'h0100_0010,
                              32'h00FF_FFFC, 32'h0110_0000, 32'h010F_FFFF};

  task automatic test_errors();
    logic [31:0] rd;
    logic er;
    int lat, nw;
    for (int i = 0; i < 6; i++) begin
      do_txn(er_w[i], er_f3[i], er_a[i], 32'hA5A5_A5A5, rd, er, lat, nw);
      checks++;
      if (er !== 1'b1 || rd !== 32'h0 || lat != 1 || nw != 0) begin
        fails++;
        $display("FAIL error[%0d]: err=%b rdata=%h lat=%0d writes=%0d, required 1 0 1 0",
                 i, er, rd, lat, nw);
      end
    end
    do_txn(1'b0, 3'b010, 32'h010F_FFFC, 32'h0, rd, er, lat, nw);
    checks++;
    if (er !== 1'b0 || rd !== 32'h0 || lat != 2) begin
      fails++;
      $display("FAIL lw_top_edge: err=%b rdata=%h lat=%0d, required 0 0 2", er, rd, lat);
    end
    do_txn(1'b0, 3'b100, 32'h010F_FFFF, 32'h0, rd, er, lat, nw);
    checks++;
    if (er !== 1'b0 || lat != 2) begin
      fails++;
      $display("FAIL lbu_last_byte: err=%b lat=%0d, required 0 2", er, lat);
    end
  endtask

  task automatic test_backpressure();
    int lat;
    issue(1'b0, 3'b010, BASE + 32'h10, 32'h0);
    lat = 1;
    while (rsp_valid !== 1'b1 && lat < 20) begin
      @(negedge clock);
      lat++;
    end
    for (int c = 0; c < 5; c++) begin
      checks++;
      if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hDEAD80EF || rsp_error !== 1'b0 ||
          req_ready !== 1'b0 || mem_read_write !== 1'b0) begin
        fails++;
        $display("FAIL hold[%0d]: valid=%b rdata=%h err=%b ready=%b rw=%b, required 1 dead80ef 0 0 0",
                 c, rsp_valid, rsp_rdata, rsp_error, req_ready, mem_read_write);
      end
      @(negedge clock);
    end
    rsp_ready = 1'b1;
    @(posedge clock);
    @(negedge clock);
    rsp_ready = 1'b0;
    checks++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      fails++;
      $display("FAIL hold_release: ready=%b valid=%b, required 1 0", req_ready, rsp_valid);
    end
  endtask

  task automatic test_reset_mid_split();
    logic [31:0] rd;
    logic er;
    int lat, nw;
    issue(1'b1, 3'b010, BASE + 32'h31, 32'hAABBCCDD);
    @(negedge clock);
    reset_n = 1'b0;
    #1;
    checks++;
    if (rsp_valid !== 1'b0 || mem_read_write !== 1'b0 || mem_address !== BASE ||
        req_ready !== 1'b0) begin
      fails++;
      $display("FAIL split_reset_port: valid=%b rw=%b addr=%h ready=%b, required 0 0 %h 0",
               rsp_valid, mem_read_write, mem_address, req_ready, BASE);
    end
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    checks++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      fails++;
      $display("FAIL split_reset_idle: ready=%b valid=%b, required 1 0", req_ready, rsp_valid);
    end
    checks++;
    if (mem[8'h31] !== (TRAP ? 8'h00 : 8'hDD) || mem[8'h32] !== 8'h00 || mem[8'h33] !== 8'h00) begin
      fails++;
      $display("FAIL split_reset_mem: bytes=%h %h %h, required %h 00 00",
               mem[8'h31], mem[8'h32], mem[8'h33], TRAP ? 8'h00 : 8'hDD);
    end
    do_txn(1'b0, 3'b100, BASE + 32'h31, 32'h0, rd, er, lat, nw);
    checks++;
    if (rd !== (TRAP ? 32'h0 : 32'h0000_00DD) || er !== 1'b0 || lat != 2) begin
      fails++;
      $display("FAIL split_reset_readback: rdata=%h err=%b lat=%0d, required %h 0 2",
               rd, er, lat, TRAP ? 32'h0 : 32'h0000_00DD);
    end
  endtask

  initial begin
    reset_n    = 1'b0;
    req_valid  = 1'b0;
    req_write  = 1'b0;
    req_funct3 = 3'b000;
    req_addr   = 32'h0;
    req_wdata  = 32'h0;
    rsp_ready  = 1'b0;
    test_reset();
    test_aligned();
    test_load_extend();
    test_misaligned();
    test_errors();
    test_backpressure();
    test_reset_mid_split();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
    $fatal(1);
  end

endmodule
